// File: rtl/per2axi_pkg.sv
// per2axi_pkg
//   Shared types and constants for the peripheral-to-AXI request path.
//   - per2axi_state_e : request FSM states (IDLE, RD, WR)
//   - AXI_SIZE_32B    : beat size for a single 32-bit peripheral access
//   - AXI_RESP_*      : AXI response codes, shared with the response channel
//   - AXI_*_DEFAULT   : fixed AW/AR attributes for single-beat transfers.
//     Every attribute is zero, so the outputs are also zero while in reset.
//     FIXED burst is legal for a one-beat transfer.
package per2axi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } per2axi_state_e;

    localparam logic [2:0] AXI_SIZE_32B = 3'b010;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [7:0] AXI_LEN_DEFAULT    = 8'h00;
    localparam logic [1:0] AXI_BURST_DEFAULT  = 2'b00;
    localparam logic       AXI_LOCK_DEFAULT   = 1'b0;
    localparam logic [3:0] AXI_CACHE_DEFAULT  = 4'b0000;
    localparam logic [2:0] AXI_PROT_DEFAULT   = 3'b000;
    localparam logic [3:0] AXI_REGION_DEFAULT = 4'h0;
    localparam logic [3:0] AXI_QOS_DEFAULT    = 4'h0;

endpackage

// File: rtl/per2axi_req_channel_if.sv
// per2axi_req_channel_if
//   Bundles the peripheral-slave request port and the AXI AW/W/AR master
//   channels of the request path.
//   modport master : the bridge view (takes peripheral requests, drives AXI)
//   modport slave  : the environment view (initiator plus AXI slave)
interface per2axi_req_channel_if #(
    parameter int unsigned PER_ADDR_WIDTH = 32,
    parameter int unsigned PER_ID_WIDTH   = 5,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_USER_WIDTH = 6,
    parameter int unsigned AXI_ID_WIDTH   = 3
) ();

    // Peripheral slave side
    logic                        per_slave_req;
    logic [PER_ADDR_WIDTH-1:0]   per_slave_add;
    logic                        per_slave_we;
    logic [31:0]                 per_slave_wdata;
    logic [3:0]                  per_slave_be;
    logic [PER_ID_WIDTH-1:0]     per_slave_id;
    logic                        per_slave_gnt;

    // AW channel
    logic                        axi_master_aw_valid;
    logic                        axi_master_aw_ready;
    logic [AXI_ADDR_WIDTH-1:0]   axi_master_aw_addr;
    logic [AXI_ID_WIDTH-1:0]     axi_master_aw_id;
    logic [2:0]                  axi_master_aw_size;
    logic [AXI_USER_WIDTH-1:0]   axi_master_aw_user;
    logic [7:0]                  axi_master_aw_len;
    logic [1:0]                  axi_master_aw_burst;
    logic                        axi_master_aw_lock;
    logic [3:0]                  axi_master_aw_cache;
    logic [2:0]                  axi_master_aw_prot;
    logic [3:0]                  axi_master_aw_region;
    logic [3:0]                  axi_master_aw_qos;

    // W channel
    logic                        axi_master_w_valid;
    logic                        axi_master_w_ready;
    logic [AXI_DATA_WIDTH-1:0]   axi_master_w_data;
    logic [AXI_DATA_WIDTH/8-1:0] axi_master_w_strb;
    logic                        axi_master_w_last;
    logic [AXI_USER_WIDTH-1:0]   axi_master_w_user;

    // AR channel
    logic                        axi_master_ar_valid;
    logic                        axi_master_ar_ready;
    logic [AXI_ADDR_WIDTH-1:0]   axi_master_ar_addr;
    logic [AXI_ID_WIDTH-1:0]     axi_master_ar_id;
    logic [2:0]                  axi_master_ar_size;
    logic [AXI_USER_WIDTH-1:0]   axi_master_ar_user;
    logic [7:0]                  axi_master_ar_len;
    logic [1:0]                  axi_master_ar_burst;
    logic                        axi_master_ar_lock;
    logic [3:0]                  axi_master_ar_cache;
    logic [2:0]                  axi_master_ar_prot;
    logic [3:0]                  axi_master_ar_region;
    logic [3:0]                  axi_master_ar_qos;

    modport master (
        input  per_slave_req, per_slave_add, per_slave_we, per_slave_wdata,
               per_slave_be, per_slave_id,
        output per_slave_gnt,
        output axi_master_aw_valid, axi_master_aw_addr, axi_master_aw_id,
               axi_master_aw_size, axi_master_aw_user, axi_master_aw_len,
               axi_master_aw_burst, axi_master_aw_lock, axi_master_aw_cache,
               axi_master_aw_prot, axi_master_aw_region, axi_master_aw_qos,
        input  axi_master_aw_ready,
        output axi_master_w_valid, axi_master_w_data, axi_master_w_strb,
               axi_master_w_last, axi_master_w_user,
        input  axi_master_w_ready,
        output axi_master_ar_valid, axi_master_ar_addr, axi_master_ar_id,
               axi_master_ar_size, axi_master_ar_user, axi_master_ar_len,
               axi_master_ar_burst, axi_master_ar_lock, axi_master_ar_cache,
               axi_master_ar_prot, axi_master_ar_region, axi_master_ar_qos,
        input  axi_master_ar_ready
    );

    modport slave (
        output per_slave_req, per_slave_add, per_slave_we, per_slave_wdata,
               per_slave_be, per_slave_id,
        input  per_slave_gnt,
        input  axi_master_aw_valid, axi_master_aw_addr, axi_master_aw_id,
               axi_master_aw_size, axi_master_aw_user, axi_master_aw_len,
               axi_master_aw_burst, axi_master_aw_lock, axi_master_aw_cache,
               axi_master_aw_prot, axi_master_aw_region, axi_master_aw_qos,
        output axi_master_aw_ready,
        input  axi_master_w_valid, axi_master_w_data, axi_master_w_strb,
               axi_master_w_last, axi_master_w_user,
        output axi_master_w_ready,
        input  axi_master_ar_valid, axi_master_ar_addr, axi_master_ar_id,
               axi_master_ar_size, axi_master_ar_user, axi_master_ar_len,
               axi_master_ar_burst, axi_master_ar_lock, axi_master_ar_cache,
               axi_master_ar_prot, axi_master_ar_region, axi_master_ar_qos,
        output axi_master_ar_ready
    );

endinterface

// File: rtl/per2axi_id_enc.sv
// per2axi_id_enc
//   Priority encoder from a one-hot initiator ID to a binary AXI ID.
//   The lowest set bit wins, so a malformed ID still gives a defined result.
//   i_onehot : PER_ID_WIDTH one-hot initiator ID
//   o_bin    : AXI_ID_WIDTH index of the lowest set bit (0 when none is set)
module per2axi_id_enc #(
    parameter int unsigned PER_ID_WIDTH = 5,
    parameter int unsigned AXI_ID_WIDTH = 3
) (
    input  logic [PER_ID_WIDTH-1:0] i_onehot,
    output logic [AXI_ID_WIDTH-1:0] o_bin
);

    logic w_found;

    always_comb begin
        o_bin   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < PER_ID_WIDTH; i++) begin
            if (i_onehot[i] && !w_found) begin
                o_bin   = AXI_ID_WIDTH'(i);
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/per2axi_req_channel.sv
// per2axi_req_channel
//   Request path of the peripheral-to-AXI bridge. Each granted 32-bit
//   peripheral request becomes one single-beat AXI4 read (AR) or write
//   (AW+W). Only one AXI request is on the bus at a time. One response per
//   peripheral ID may be outstanding.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   bus (master modport) : peripheral request/grant plus AXI AW/W/AR channels
//   trans_req_o/_id_o/_add_o : read-accept pulse with binary ID and address,
//                              used by the response channel for lane select
//   rsp_done_i/rsp_id_i  : response delivered; clears that ID's outstanding bit
module per2axi_req_channel
    import per2axi_pkg::*;
#(
    parameter int unsigned PER_ADDR_WIDTH = 32,
    parameter int unsigned PER_ID_WIDTH   = 5,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_USER_WIDTH = 6,
    parameter int unsigned AXI_ID_WIDTH   = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    per2axi_req_channel_if.master     bus,
    output logic                      trans_req_o,
    output logic [AXI_ID_WIDTH-1:0]   trans_id_o,
    output logic [AXI_ADDR_WIDTH-1:0] trans_add_o,
    input  logic                      rsp_done_i,
    input  logic [AXI_ID_WIDTH-1:0]   rsp_id_i
);

    localparam int unsigned NUM_IDS = 1 << AXI_ID_WIDTH;
    localparam int unsigned STRB_W  = AXI_DATA_WIDTH / 8;

    per2axi_state_e             r_state, w_state_nxt;
    logic                       r_aw_valid, w_aw_valid_nxt;
    logic                       r_w_valid, w_w_valid_nxt;
    logic                       r_ar_valid, w_ar_valid_nxt;
    logic [NUM_IDS-1:0]         r_outstanding;
    logic [NUM_IDS-1:0]         w_set, w_clr;
    logic [PER_ADDR_WIDTH-1:0]  r_add;
    logic [31:0]                r_wdata;
    logic [3:0]                 r_be;
    logic [AXI_ID_WIDTH-1:0]    r_id;
    logic [AXI_ID_WIDTH-1:0]    w_id_bin;
    logic                       w_gnt;

    per2axi_id_enc #(
        .PER_ID_WIDTH (PER_ID_WIDTH),
        .AXI_ID_WIDTH (AXI_ID_WIDTH)
    ) u_id_enc (
        .i_onehot (bus.per_slave_id),
        .o_bin    (w_id_bin)
    );

    // rst_ni is in the grant term so that gnt and the trans_* outputs
    // are also zero while reset is held.
    assign w_gnt = bus.per_slave_req & rst_ni & (r_state == IDLE)
                 & ~r_outstanding[w_id_bin];

    always_comb begin
        w_state_nxt    = r_state;
        w_aw_valid_nxt = r_aw_valid;
        w_w_valid_nxt  = r_w_valid;
        w_ar_valid_nxt = r_ar_valid;
        unique case (r_state)
            IDLE: begin
                if (w_gnt) begin
                    if (bus.per_slave_we) begin
                        w_state_nxt    = RD;
                        w_ar_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = WR;
                        w_aw_valid_nxt = 1'b1;
                        w_w_valid_nxt  = 1'b1;
                    end
                end
            end
            RD: begin
                if (bus.axi_master_ar_ready) begin
                    w_state_nxt    = IDLE;
                    w_ar_valid_nxt = 1'b0;
                end
            end
            WR: begin
                // AW and W retire independently. Leave once neither is pending.
                w_aw_valid_nxt = r_aw_valid & ~bus.axi_master_aw_ready;
                w_w_valid_nxt  = r_w_valid & ~bus.axi_master_w_ready;
                if (!w_aw_valid_nxt && !w_w_valid_nxt) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_aw_valid_nxt = 1'b0;
                w_w_valid_nxt  = 1'b0;
                w_ar_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_ar_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_aw_valid <= w_aw_valid_nxt;
            r_w_valid  <= w_w_valid_nxt;
            r_ar_valid <= w_ar_valid_nxt;
        end
    end

    // The buffer is written only on a grant. A grant only happens in IDLE,
    // so the payload stays stable while any valid is high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_add   <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_id    <= '0;
        end else if (w_gnt) begin
            r_add   <= bus.per_slave_add;
            r_wdata <= bus.per_slave_wdata;
            r_be    <= bus.per_slave_be;
            r_id    <= w_id_bin;
        end
    end

    // A set and a clear of different IDs in one cycle both take effect. A
    // same-ID set and clear cannot happen, because a grant needs the bit clear.
    assign w_set = w_gnt ? (NUM_IDS'(1) << w_id_bin) : '0;
    assign w_clr = rsp_done_i ? (NUM_IDS'(1) << rsp_id_i) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= (r_outstanding & ~w_clr) | w_set;
        end
    end

    assign bus.per_slave_gnt = w_gnt;

    assign trans_req_o = w_gnt & bus.per_slave_we;
    assign trans_id_o  = trans_req_o ? w_id_bin : '0;
    assign trans_add_o = trans_req_o ? AXI_ADDR_WIDTH'(bus.per_slave_add) : '0;

    assign bus.axi_master_aw_valid  = r_aw_valid;
    assign bus.axi_master_aw_addr   = AXI_ADDR_WIDTH'(r_add);
    assign bus.axi_master_aw_id     = r_id;
    assign bus.axi_master_aw_size   = r_aw_valid ? AXI_SIZE_32B : 3'b000;
    assign bus.axi_master_aw_user   = {AXI_USER_WIDTH{1'b0}};
    assign bus.axi_master_aw_len    = AXI_LEN_DEFAULT;
    assign bus.axi_master_aw_burst  = AXI_BURST_DEFAULT;
    assign bus.axi_master_aw_lock   = AXI_LOCK_DEFAULT;
    assign bus.axi_master_aw_cache  = AXI_CACHE_DEFAULT;
    assign bus.axi_master_aw_prot   = AXI_PROT_DEFAULT;
    assign bus.axi_master_aw_region = AXI_REGION_DEFAULT;
    assign bus.axi_master_aw_qos    = AXI_QOS_DEFAULT;

    // Address bit 2 selects the upper or lower 32-bit lane of the 64-bit beat.
    assign bus.axi_master_w_valid = r_w_valid;
    assign bus.axi_master_w_data  = r_add[2] ? {r_wdata, 32'h0} : {32'h0, r_wdata};
    assign bus.axi_master_w_strb  = r_add[2] ? STRB_W'({r_be, 4'h0}) : STRB_W'({4'h0, r_be});
    assign bus.axi_master_w_last  = r_w_valid;
    assign bus.axi_master_w_user  = {AXI_USER_WIDTH{1'b0}};

    assign bus.axi_master_ar_valid  = r_ar_valid;
    assign bus.axi_master_ar_addr   = AXI_ADDR_WIDTH'(r_add);
    assign bus.axi_master_ar_id     = r_id;
    assign bus.axi_master_ar_size   = r_ar_valid ? AXI_SIZE_32B : 3'b000;
    assign bus.axi_master_ar_user   = {AXI_USER_WIDTH{1'b0}};
    assign bus.axi_master_ar_len    = AXI_LEN_DEFAULT;
    assign bus.axi_master_ar_burst  = AXI_BURST_DEFAULT;
    assign bus.axi_master_ar_lock   = AXI_LOCK_DEFAULT;
    assign bus.axi_master_ar_cache  = AXI_CACHE_DEFAULT;
    assign bus.axi_master_ar_prot   = AXI_PROT_DEFAULT;
    assign bus.axi_master_ar_region = AXI_REGION_DEFAULT;
    assign bus.axi_master_ar_qos    = AXI_QOS_DEFAULT;

    a_id_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.per_slave_req |-> $onehot(bus.per_slave_id));

    a_clr_set_bit: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_done_i |-> r_outstanding[rsp_id_i]);

endmodule

// File: tb/tb_per2axi_req_channel.sv
module tb_per2axi_req_channel;

    localparam int unsigned PAW = 32;
    localparam int unsigned PIW = 5;
    localparam int unsigned AAW = 32;
    localparam int unsigned ADW = 64;
    localparam int unsigned AUW = 6;
    localparam int unsigned AIW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    per2axi_req_channel_if #(
        .PER_ADDR_WIDTH (PAW), .PER_ID_WIDTH (PIW), .AXI_ADDR_WIDTH (AAW),
        .AXI_DATA_WIDTH (ADW), .AXI_USER_WIDTH (AUW), .AXI_ID_WIDTH (AIW)
    ) bus ();

    logic           trans_req;
    logic [AIW-1:0] trans_id;
    logic [AAW-1:0] trans_add;
    logic           rsp_done = 1'b0;
    logic [AIW-1:0] rsp_id = '0;

    per2axi_req_channel #(
        .PER_ADDR_WIDTH (PAW), .PER_ID_WIDTH (PIW), .AXI_ADDR_WIDTH (AAW),
        .AXI_DATA_WIDTH (ADW), .AXI_USER_WIDTH (AUW), .AXI_ID_WIDTH (AIW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus.master),
        .trans_req_o (trans_req),
        .trans_id_o  (trans_id),
        .trans_add_o (trans_add),
        .rsp_done_i  (rsp_done),
        .rsp_id_i    (rsp_id)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction-level model. It tracks which IDs await a response and
    // which legs of the single in-flight AXI request are still pending.
    bit          pend [8];
    bit          m_act, m_rd, m_ar, m_aw, m_w;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    int          m_id;

    always @(negedge clk) begin
        bit exp_gnt;
        int idx;
        logic [63:0] exp_data;
        logic [7:0]  exp_strb;
        if (!rst_n) begin
            chk("rst_gnt", bus.per_slave_gnt, 0);
            chk("rst_aw_valid", bus.axi_master_aw_valid, 0);
            chk("rst_w_valid", bus.axi_master_w_valid, 0);
            chk("rst_ar_valid", bus.axi_master_ar_valid, 0);
            chk("rst_trans_req", trans_req, 0);
            chk("rst_aw_addr", bus.axi_master_aw_addr, 0);
            chk("rst_w_data", bus.axi_master_w_data, 0);
            chk("rst_w_last", bus.axi_master_w_last, 0);
            chk("rst_ar_size", bus.axi_master_ar_size, 0);
            chk("rst_aw_burst", bus.axi_master_aw_burst, 0);
            for (int i = 0; i < 8; i++) pend[i] = 1'b0;
            m_act = 0; m_rd = 0; m_ar = 0; m_aw = 0; m_w = 0;
        end else begin
            idx = $clog2(bus.per_slave_id);
            exp_gnt = bus.per_slave_req && !m_act && !pend[idx];
            chk("gnt", bus.per_slave_gnt, exp_gnt);
            chk("trans_req", trans_req, exp_gnt && bus.per_slave_we);
            if (exp_gnt && bus.per_slave_we) begin
                chk("trans_id", trans_id, idx);
                chk("trans_add", trans_add, bus.per_slave_add);
            end
            chk("ar_valid", bus.axi_master_ar_valid, m_act && m_rd && m_ar);
            chk("aw_valid", bus.axi_master_aw_valid, m_act && !m_rd && m_aw);
            chk("w_valid", bus.axi_master_w_valid, m_act && !m_rd && m_w);
            if (m_act && m_rd && m_ar) begin
                chk("ar_addr", bus.axi_master_ar_addr, m_addr);
                chk("ar_id", bus.axi_master_ar_id, m_id);
                chk("ar_size", bus.axi_master_ar_size, 2);
            end
            if (m_act && !m_rd && m_aw) begin
                chk("aw_addr", bus.axi_master_aw_addr, m_addr);
                chk("aw_id", bus.axi_master_aw_id, m_id);
                chk("aw_size", bus.axi_master_aw_size, 2);
            end
            if (m_act && !m_rd && m_w) begin
                exp_data = {32'h0, m_wdata} << (m_addr[2] ? 32 : 0);
                exp_strb = {4'h0, m_be} << (m_addr[2] ? 4 : 0);
                chk("w_data", bus.axi_master_w_data, exp_data);
                chk("w_strb", bus.axi_master_w_strb, exp_strb);
                chk("w_last", bus.axi_master_w_last, 1);
            end
            // Advance the model to the state after the coming rising edge.
            if (m_act) begin
                if (m_ar && bus.axi_master_ar_ready) m_ar = 0;
                if (m_aw && bus.axi_master_aw_ready) m_aw = 0;
                if (m_w && bus.axi_master_w_ready) m_w = 0;
                if (!(m_ar || m_aw || m_w)) m_act = 0;
            end
            if (rsp_done) pend[rsp_id] = 1'b0;
            if (exp_gnt) begin
                pend[idx] = 1'b1;
                m_act = 1; m_rd = bus.per_slave_we;
                m_ar = bus.per_slave_we; m_aw = !bus.per_slave_we; m_w = !bus.per_slave_we;
                m_addr = bus.per_slave_add; m_wdata = bus.per_slave_wdata;
                m_be = bus.per_slave_be; m_id = idx;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit we, input logic [4:0] id, input logic [31:0] add,
                       input logic [31:0] wd, input logic [3:0] be);
        bus.per_slave_req = 1; bus.per_slave_we = we; bus.per_slave_id = id;
        bus.per_slave_add = add; bus.per_slave_wdata = wd; bus.per_slave_be = be;
    endtask

    initial begin
        int plist [$];
        bus.per_slave_req = 0; bus.per_slave_we = 0; bus.per_slave_id = 5'b00001;
        bus.per_slave_add = '0; bus.per_slave_wdata = '0; bus.per_slave_be = '0;
        bus.axi_master_aw_ready = 1; bus.axi_master_w_ready = 1; bus.axi_master_ar_ready = 1;
        repeat (3) step();
        chk("reset_ar_valid", bus.axi_master_ar_valid, 0);
        chk("reset_trans_id", trans_id, 0);
        rst_n = 1;

        // Read, id 2, address 0x1000_0004
        step();
        req(1, 5'b00100, 32'h1000_0004, 32'h0, 4'h0);
        #1;
        chk("d_rd_gnt", bus.per_slave_gnt, 1);
        chk("d_rd_trans_req", trans_req, 1);
        chk("d_rd_trans_id", trans_id, 2);
        chk("d_rd_trans_add", trans_add, 32'h1000_0004);
        step();
        bus.per_slave_req = 0;
        chk("d_rd_ar_valid", bus.axi_master_ar_valid, 1);
        chk("d_rd_ar_addr", bus.axi_master_ar_addr, 32'h1000_0004);
        chk("d_rd_ar_id", bus.axi_master_ar_id, 2);
        chk("d_rd_ar_size", bus.axi_master_ar_size, 2);
        step();
        chk("d_rd_ar_drop", bus.axi_master_ar_valid, 0);
        rsp_done = 1; rsp_id = 2;
        step();
        rsp_done = 0;

        // Write to the upper lane
        req(0, 5'b00001, 32'h2000_0004, 32'hDEAD_BEEF, 4'b0011);
        #1;
        chk("d_wr_hi_gnt", bus.per_slave_gnt, 1);
        chk("d_wr_hi_trans_req", trans_req, 0);
        step();
        bus.per_slave_req = 0;
        chk("d_wr_hi_aw_valid", bus.axi_master_aw_valid, 1);
        chk("d_wr_hi_w_data", bus.axi_master_w_data, 64'hDEAD_BEEF_0000_0000);
        chk("d_wr_hi_w_strb", bus.axi_master_w_strb, 8'h30);
        step();
        chk("d_wr_hi_done", {bus.axi_master_aw_valid, bus.axi_master_w_valid}, 0);
        rsp_done = 1; rsp_id = 0;
        step();
        rsp_done = 0;

        // Same write to the lower lane
        req(0, 5'b00010, 32'h2000_0000, 32'hDEAD_BEEF, 4'b0011);
        step();
        bus.per_slave_req = 0;
        chk("d_wr_lo_w_data", bus.axi_master_w_data, 64'h0000_0000_DEAD_BEEF);
        chk("d_wr_lo_w_strb", bus.axi_master_w_strb, 8'h03);
        step();
        rsp_done = 1; rsp_id = 1;
        step();
        rsp_done = 0;

        // W completes at N+1, AW only at N+4
        bus.axi_master_aw_ready = 0; bus.axi_master_w_ready = 1;
        req(0, 5'b01000, 32'h3000_0008, 32'h1234_5678, 4'hF);
        step();
        req(1, 5'b10000, 32'h4000_0010, 32'h0, 4'h0);
        #1;
        chk("d_split_n1_w", bus.axi_master_w_valid, 1);
        chk("d_split_n1_gnt", bus.per_slave_gnt, 0);
        step();
        chk("d_split_n2_w", bus.axi_master_w_valid, 0);
        chk("d_split_n2_aw", bus.axi_master_aw_valid, 1);
        step();
        chk("d_split_n3_aw", bus.axi_master_aw_valid, 1);
        chk("d_split_n3_gnt", bus.per_slave_gnt, 0);
        step();
        bus.axi_master_aw_ready = 1;
        chk("d_split_n4_aw", bus.axi_master_aw_valid, 1);
        step();
        chk("d_split_n5_aw", bus.axi_master_aw_valid, 0);
        chk("d_split_n5_gnt", bus.per_slave_gnt, 1);
        step();
        bus.per_slave_req = 0;
        step();

        // Same ID again before and after its response
        req(0, 5'b01000, 32'h3000_000C, 32'hCAFE_F00D, 4'h1);
        #1;
        chk("d_sameid_blocked", bus.per_slave_gnt, 0);
        step();
        rsp_done = 1; rsp_id = 3;
        #1;
        chk("d_sameid_rsp_cycle", bus.per_slave_gnt, 0);
        step();
        rsp_done = 0;
        chk("d_sameid_after_rsp", bus.per_slave_gnt, 1);
        step();
        bus.per_slave_req = 0;
        repeat (2) step();

        // Reset while AR is stalled
        bus.axi_master_ar_ready = 0;
        req(1, 5'b00001, 32'h5000_0004, 32'h0, 4'h0);
        step();
        bus.per_slave_req = 0;
        chk("d_rst_ar_before", bus.axi_master_ar_valid, 1);
        rst_n = 0;
        #1;
        chk("d_rst_ar_valid", bus.axi_master_ar_valid, 0);
        chk("d_rst_ar_addr", bus.axi_master_ar_addr, 0);
        chk("d_rst_ar_size", bus.axi_master_ar_size, 0);
        step();
        rst_n = 1;
        bus.axi_master_ar_ready = 1;
        step();
        req(1, 5'b01000, 32'h6000_0000, 32'h0, 4'h0);
        #1;
        chk("d_rst_bitmap_empty", bus.per_slave_gnt, 1);
        step();
        bus.per_slave_req = 0;
        repeat (2) step();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step();
            bus.per_slave_req   = ($urandom_range(0, 99) < 60);
            bus.per_slave_id    = 5'b00001 << $urandom_range(0, 4);
            bus.per_slave_we    = $urandom_range(0, 1);
            bus.per_slave_add   = $urandom & 32'hFFFF_FFFC;
            bus.per_slave_wdata = $urandom;
            bus.per_slave_be    = 4'($urandom);
            bus.axi_master_aw_ready = ($urandom_range(0, 99) < 50);
            bus.axi_master_w_ready  = ($urandom_range(0, 99) < 50);
            bus.axi_master_ar_ready = ($urandom_range(0, 99) < 60);
            plist.delete();
            for (int i = 0; i < 5; i++) if (pend[i]) plist.push_back(i);
            if (plist.size() != 0 && $urandom_range(0, 99) < 30) begin
                rsp_done = 1;
                rsp_id = 3'(plist[$urandom_range(0, plist.size() - 1)]);
            end else begin
                rsp_done = 0;
            end
        end
        step();
        bus.per_slave_req = 0; rsp_done = 0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
